// File: rtl/ysyx_24100005_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory port (slave).
// One request channel with ready/valid and a single-cycle response channel.
interface ysyx_24100005_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_wmask;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one access at a time over a handshaked memory bus,
// with lane alignment of store data and extension of load data.
module ysyx_24100005_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [2:0]            in_funct3,
  input  logic                  in_is_store,
  ysyx_24100005_lsu_if.master   mem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rdata,
  output logic                  out_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
    logic              is_store;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  function automatic logic legal(input logic [2:0] f3, input logic st);
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !st;
      3'b011:                 legal = (DATA_W == 64);
      3'b110:                 legal = (DATA_W == 64) && !st;
      default:                legal = 1'b0;
    endcase
  endfunction

  function automatic logic aligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    case (sz)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !off[0];
      2'd2:    aligned = (off[1:0] == 2'b00);
      default: aligned = (off == '0);
    endcase
  endfunction

  logic acc_ok;
  assign acc_ok = legal(in_funct3, in_is_store) && aligned(in_funct3[1:0], in_addr[OFF_W-1:0]);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)       state_nxt = acc_ok ? REQ : RESP;
      REQ:     if (mem.req_ready)  state_nxt = WAIT;
      WAIT:    if (mem.resp_valid) state_nxt = RESP;
      RESP:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Lane position of the access inside the bus word, as byte and bit offsets.
  logic [OFF_W-1:0] off_q;
  logic [OFF_W+2:0] sh_q;
  logic [NB-1:0]    size_mask;
  assign off_q = req_q.addr[OFF_W-1:0];
  assign sh_q  = {off_q, 3'b000};

  always_comb begin
    case (req_q.funct3[1:0])
      2'd0:    size_mask = NB'(1);
      2'd1:    size_mask = NB'(3);
      2'd2:    size_mask = NB'(15);
      default: size_mask = '1;
    endcase
  end

  assign mem.req_valid = (state == REQ);
  assign mem.req_addr  = {req_q.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem.req_wen   = (state == REQ) && req_q.is_store;
  assign mem.req_wdata = req_q.wdata << sh_q;
  assign mem.req_wmask = mem.req_wen ? (size_mask << off_q) : '0;

  logic [DATA_W-1:0] rsh, load_fmt;
  assign rsh = mem.resp_rdata >> sh_q;

  // LW sign-extends on a 64-bit bus and degenerates to a pass-through at 32 bits.
  always_comb begin
    case (req_q.funct3)
      3'b000:  load_fmt = DATA_W'($signed(rsh[7:0]));
      3'b001:  load_fmt = DATA_W'($signed(rsh[15:0]));
      3'b010:  load_fmt = DATA_W'($signed(rsh[31:0]));
      3'b100:  load_fmt = DATA_W'(rsh[7:0]);
      3'b101:  load_fmt = DATA_W'(rsh[15:0]);
      3'b110:  load_fmt = DATA_W'(rsh[31:0]);
      default: load_fmt = rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      req_q   <= '{addr: in_addr, wdata: in_wdata, funct3: in_funct3, is_store: in_is_store};
      rdata_q <= '0;
      err_q   <= !acc_ok;
    end else if (state == WAIT && mem.resp_valid) begin
      rdata_q <= (mem.resp_err || req_q.is_store) ? '0 : load_fmt;
      err_q   <= mem.resp_err;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign out_rdata = rdata_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench: a 32-bit and a 64-bit LSU share stimulus; sel picks which one is driven and observed.
module tb_ysyx_24100005_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v32 = 1'b0, v64 = 1'b0;
  logic [31:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_store = 1'b0;
  logic        req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0, out_ready = 1'b1;
  logic [63:0] resp_rdata = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu_if #(.DATA_W(32), .ADDR_W(32)) m32 ();
  ysyx_24100005_lsu_if #(.DATA_W(64), .ADDR_W(32)) m64 ();

  assign m32.req_ready  = req_ready;
  assign m32.resp_valid = resp_valid;
  assign m32.resp_rdata = resp_rdata[31:0];
  assign m32.resp_err   = resp_err;
  assign m64.req_ready  = req_ready;
  assign m64.resp_valid = resp_valid;
  assign m64.resp_rdata = resp_rdata;
  assign m64.resp_err   = resp_err;

  logic        r32, ov32, oe32, r64, ov64, oe64;
  logic [31:0] od32;
  logic [63:0] od64;

  ysyx_24100005_lsu #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_addr(in_addr),
    .in_wdata(in_wdata[31:0]), .in_funct3(in_funct3), .in_is_store(in_is_store),
    .mem(m32), .out_valid(ov32), .out_ready(out_ready), .out_rdata(od32), .out_err(oe32));

  ysyx_24100005_lsu #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_funct3(in_funct3), .in_is_store(in_is_store),
    .mem(m64), .out_valid(ov64), .out_ready(out_ready), .out_rdata(od64), .out_err(oe64));

  logic        o_in_ready, o_req_valid, o_wen, o_out_valid, o_err;
  logic [31:0] o_addr;
  logic [63:0] o_wdata, o_rdata;
  logic [7:0]  o_wmask;
  assign o_in_ready  = sel ? r64 : r32;
  assign o_req_valid = sel ? m64.req_valid : m32.req_valid;
  assign o_addr      = sel ? m64.req_addr : m32.req_addr;
  assign o_wen       = sel ? m64.req_wen : m32.req_wen;
  assign o_wdata     = sel ? m64.req_wdata : {32'h0, m32.req_wdata};
  assign o_wmask     = sel ? m64.req_wmask : {4'h0, m32.req_wmask};
  assign o_out_valid = sel ? ov64 : ov32;
  assign o_rdata     = sel ? od64 : {32'h0, od32};
  assign o_err       = sel ? oe64 : oe32;

  int checks = 0, failures = 0;
  int hs32 = 0, reqcnt = 0;

  always @(posedge clk) begin
    if (ov32 && out_ready) hs32 <= hs32 + 1;
    if (m32.req_valid || m64.req_valid) reqcnt <= reqcnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Legal access with immediate bus ready/response: accept, handshake, response, out_valid.
  task automatic access(input string tag, input logic s64, input logic [31:0] a,
                        input logic [63:0] wd, input logic [2:0] fn, input logic st,
                        input logic [63:0] rd, input logic re, input logic [31:0] ex_addr,
                        input logic [7:0] ex_mask, input logic [63:0] ex_wd,
                        input logic [63:0] ex_out, input logic ex_err);
    sel = s64; in_addr = a; in_wdata = wd; in_funct3 = fn; in_is_store = st;
    req_ready = 1'b1; out_ready = 1'b1;
    chk({tag, ".in_ready"}, o_in_ready, 1);
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    step();
    v32 = 1'b0; v64 = 1'b0;
    chk({tag, ".req_valid"}, o_req_valid, 1);
    chk({tag, ".addr"}, o_addr, ex_addr);
    chk({tag, ".wen"}, o_wen, st);
    chk({tag, ".wmask"}, o_wmask, ex_mask);
    if (st) chk({tag, ".wdata"}, o_wdata, ex_wd);
    chk({tag, ".busy"}, o_in_ready, 0);
    step();
    resp_valid = 1'b1; resp_rdata = rd; resp_err = re;
    chk({tag, ".early_out"}, o_out_valid, 0);
    step();
    resp_valid = 1'b0; resp_err = 1'b0;
    chk({tag, ".out_valid"}, o_out_valid, 1);
    chk({tag, ".rdata"}, o_rdata, ex_out);
    chk({tag, ".err"}, o_err, ex_err);
    step();
    chk({tag, ".done"}, o_out_valid, 0);
    chk({tag, ".idle"}, o_in_ready, 1);
  endtask

  // Misaligned/illegal access: error result one cycle after accept, no bus request.
  task automatic bad(input string tag, input logic s64, input logic [31:0] a,
                     input logic [2:0] fn, input logic st);
    int rc0;
    rc0 = reqcnt;
    sel = s64; in_addr = a; in_wdata = 64'h55; in_funct3 = fn; in_is_store = st;
    req_ready = 1'b1; out_ready = 1'b1;
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    step();
    v32 = 1'b0; v64 = 1'b0;
    chk({tag, ".out_valid"}, o_out_valid, 1);
    chk({tag, ".err"}, o_err, 1);
    chk({tag, ".rdata"}, o_rdata, 0);
    chk({tag, ".req_valid"}, o_req_valid, 0);
    step();
    chk({tag, ".idle"}, o_in_ready, 1);
    chk({tag, ".no_req"}, reqcnt - rc0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int hs0;
    rst = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst.in_ready", o_in_ready, 1);
      chk("rst.req_valid", o_req_valid, 0);
      chk("rst.wen", o_wen, 0);
      chk("rst.wmask", o_wmask, 0);
      chk("rst.out_valid", o_out_valid, 0);
      chk("rst.rdata", o_rdata, 0);
      chk("rst.err", o_err, 0);
    end
    rst = 1'b0;
    step();

    // 32-bit loads and stores
    access("lb",  0, 32'h8000_0003, 64'h0, 3'b000, 0, 64'h80FF_1234, 0, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FF80, 0);
    access("sh",  0, 32'h8000_0002, 64'hABCD, 3'b001, 1, 64'hDEAD_BEEF, 0, 32'h8000_0000, 8'h0C, 64'hABCD_0000, 64'h0, 0);
    access("lw",  0, 32'h8000_0004, 64'h0, 3'b010, 0, 64'h1234_5678, 0, 32'h8000_0004, 8'h00, 64'h0, 64'h1234_5678, 0);
    access("lh",  0, 32'h8000_0000, 64'h0, 3'b001, 0, 64'h0000_8001, 0, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_8001, 0);
    access("lhu", 0, 32'h8000_0002, 64'h0, 3'b101, 0, 64'hBEEF_1234, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_BEEF, 0);
    access("sw",  0, 32'h8000_0008, 64'h1122_3344, 3'b010, 1, 64'h0, 0, 32'h8000_0008, 8'h0F, 64'h1122_3344, 64'h0, 0);
    access("sb",  0, 32'h8000_0009, 64'hAB, 3'b000, 1, 64'h0, 0, 32'h8000_0008, 8'h02, 64'hAB00, 64'h0, 0);
    access("buserr", 0, 32'h8000_000C, 64'h0, 3'b010, 0, 64'hFFFF_FFFF, 1, 32'h8000_000C, 8'h00, 64'h0, 64'h0, 1);

    // 32-bit illegal/misaligned
    bad("lw_mis",  0, 32'h8000_0001, 3'b010, 0);
    bad("sbu_ill", 0, 32'h8000_0000, 3'b100, 1);
    bad("lh_mis",  0, 32'h8000_0003, 3'b001, 0);
    bad("ld32",    0, 32'h8000_0000, 3'b011, 0);
    bad("lwu32",   0, 32'h8000_0000, 3'b110, 0);
    bad("f3_111",  0, 32'h8000_0000, 3'b111, 0);

    // Backpressure on both request and result channels
    sel = 0; in_addr = 32'h8000_0010; in_funct3 = 3'b010; in_is_store = 0;
    req_ready = 0; out_ready = 1; hs0 = hs32;
    v32 = 1'b1;
    step();
    v32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.req_valid", o_req_valid, 1);
      chk("bp.addr", o_addr, 32'h8000_0010);
      chk("bp.wmask", o_wmask, 0);
      chk("bp.in_ready", o_in_ready, 0);
      step();
    end
    req_ready = 1;
    chk("bp.req_valid_last", o_req_valid, 1);
    step();
    out_ready = 0; resp_valid = 1; resp_rdata = 64'hCAFE_F00D;
    step();
    resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.out_valid", o_out_valid, 1);
      chk("bp.rdata", o_rdata, 64'hCAFE_F00D);
      chk("bp.err", o_err, 0);
      chk("bp.in_ready_out", o_in_ready, 0);
      step();
    end
    out_ready = 1;
    chk("bp.out_valid_last", o_out_valid, 1);
    step();
    chk("bp.done", o_out_valid, 0);
    chk("bp.idle", o_in_ready, 1);
    chk("bp.one_resp", hs32 - hs0, 1);

    // Reset while waiting for the response; the late response must be dropped
    sel = 0; in_addr = 32'h8000_0020; in_funct3 = 3'b010; in_is_store = 0;
    req_ready = 1; hs0 = hs32;
    v32 = 1'b1;
    step();
    v32 = 1'b0;
    step();
    chk("rw.wait", o_out_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw.in_ready", o_in_ready, 1);
    chk("rw.req_valid", o_req_valid, 0);
    chk("rw.out_valid", o_out_valid, 0);
    step();
    resp_valid = 1; resp_rdata = 64'h1111_1111;
    step();
    resp_valid = 0;
    chk("rw.late_out", o_out_valid, 0);
    chk("rw.late_idle", o_in_ready, 1);
    step();
    chk("rw.no_hs", hs32 - hs0, 0);
    access("lbu", 0, 32'h8000_0001, 64'h0, 3'b100, 0, 64'h0000_F000, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_00F0, 0);

    // 64-bit bus
    access("lwu64", 1, 32'h8000_0004, 64'h0, 3'b110, 0, 64'h8765_4321_0000_0000, 0, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_8765_4321, 0);
    access("lw64",  1, 32'h8000_0004, 64'h0, 3'b010, 0, 64'h8765_4321_0000_0000, 0, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0);
    access("ld64",  1, 32'h8000_0008, 64'h0, 3'b011, 0, 64'h0123_4567_89AB_CDEF, 0, 32'h8000_0008, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    access("lb64",  1, 32'h8000_0007, 64'h0, 3'b000, 0, 64'h8000_0000_0000_0000, 0, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    access("sw64",  1, 32'h8000_0004, 64'hDEAD_BEEF, 3'b010, 1, 64'h0, 0, 32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0);
    access("sh64",  1, 32'h8000_0006, 64'hABCD, 3'b001, 1, 64'h0, 0, 32'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 0);
    access("sd64",  1, 32'h8000_0010, 64'h1122_3344_5566_7788, 3'b011, 1, 64'h0, 0, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0);
    bad("ld64_mis",  1, 32'h8000_0004, 3'b011, 0);
    bad("swu64_ill", 1, 32'h8000_0000, 3'b110, 1);
    bad("f3_111_64", 1, 32'h8000_0000, 3'b111, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
